column_scheduler: RTL and testbench
===================================

// Module: column_scheduler
// PURPOSE
//  Sequences one angular slice of display: on each slice_sync, waits a settle delay, then for
//  each of N_COLUMNS columns requests the LED drivers to load that column's data, and on their
//  ack pulses column_ready to the column mux. It then holds for the mux display window plus an
//  anti-ghosting blank. Sits between the rotation-sync logic, the driver load logic and column_mux.
// PARAMETERS
//  SYNC_TO_FIRST_COL_TIME  10   clk_33 cycles from slice_sync to first load request (min 1)
//  COLUMN_DISP_TIME        10   clk_33 cycles column stays lit; must equal the mux's own setting
//  ANTIGHOSTING_TIME       10   clk_33 cycles all columns dark before next load request (min 1)
//  N_COLUMNS               8    columns per slice (2..8)
//  REQ_TIMEOUT             64   max clk_33 cycles waiting for drv_data_ready before skipping column
//  SLICE_CNT_W             8    width of slice counter
// PORTS
//  clk_33         in   1   system clock, 33.33 MHz
//  nrst           in   1   reset, asynchronous, active-low
//  enable         in   1   level; 0 = finish nothing, return to IDLE next cycle
//  slice_sync     in   1   1-cycle pulse, start of angular slice
//  drv_data_ready in   1   1-cycle ack: drivers hold data for col_idx
//  drv_load_req   out  1   level request to drivers to load column col_idx
//  col_idx        out  3   column currently requested/displayed, 0..N_COLUMNS-1
//  column_ready   out  1   1-cycle pulse to column_mux
//  busy           out  1   high in every state except IDLE and WAIT_SYNC
//  slice_count    out  SLICE_CNT_W  slices started since reset, wraps to 0
//  overrun_err    out  1   sticky: slice_sync arrived while busy
//  late_err       out  1   sticky: drv_data_ready timed out
//  clr_err        in   1   1-cycle pulse clears both sticky errors
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0. Outputs registered (1-cycle latency from state).
//  States: IDLE, WAIT_SYNC, SYNC_DELAY, REQ, HOLD, GHOST. One down-counter cnt shared by timed states.
//  IDLE: enable=1 -> WAIT_SYNC. enable=0 in any state -> IDLE next cycle, drv_load_req=0, col_idx=0.
//  WAIT_SYNC: slice_sync -> SYNC_DELAY, cnt=SYNC_TO_FIRST_COL_TIME-1, col_idx=0, slice_count+1.
//  SYNC_DELAY: cnt==0 -> REQ, cnt=REQ_TIMEOUT-1.
//  REQ: drv_load_req=1. drv_data_ready -> column_ready pulse next cycle, HOLD, cnt=COLUMN_DISP_TIME-1.
//   cnt==0 without ack -> late_err=1, no column_ready, go to GHOST (column skipped).
//   Ack and timeout same cycle: ack wins.
//  HOLD: drv_load_req=0; cnt==0 -> GHOST, cnt=ANTIGHOSTING_TIME-1.
//  GHOST: cnt==0 -> if col_idx==N_COLUMNS-1: WAIT_SYNC, col_idx held; else REQ, col_idx+1,
//   cnt=REQ_TIMEOUT-1.
//  slice_sync in SYNC_DELAY/REQ/HOLD/GHOST: overrun_err=1, restart SYNC_DELAY, col_idx=0,
//   slice_count+1. A column_ready already scheduled for next cycle still fires.
//  drv_data_ready outside REQ ignored. clr_err and a new error same cycle: error wins (stays 1).
//  Column period = load wait + COLUMN_DISP_TIME + ANTIGHOSTING_TIME; mux holds column lit
//   COLUMN_DISP_TIME cycles after column_ready, so HOLD must not be shorter.
//  slice_count wraps 2^SLICE_CNT_W-1 -> 0 silently.
// TESTING
//  1 reset, enable=1, slice_sync, ack 2 cycles after each req -> 8 column_ready pulses, col_idx 0..7,
//    first req 10 cycles after sync, then WAIT_SYNC, busy=0, slice_count=1.
//  2 Ack withheld for col 3 -> late_err=1 after 64 cycles, no column_ready for col 3, col 4 proceeds.
//  3 slice_sync during HOLD of col 5 -> overrun_err=1, restart at col 0 after 10-cycle delay,
//    slice_count incremented.
//  4 enable dropped during REQ -> IDLE next cycle, drv_load_req=0, later syncs ignored.
//  5 nrst asserted mid-HOLD -> all outputs 0 immediately (async), restart requires enable+sync.
//  6 256 slices -> slice_count wraps to 0; clr_err pulse -> both errors 0.

Source files
------------

// File: rtl/column_scheduler.sv
// Per-slice column sequencer: after slice_sync and a settle delay it requests each column
// from the LED drivers, pulses column_ready on their ack, then holds for display and blanking.
module column_scheduler #(
   parameter int SYNC_TO_FIRST_COL_TIME = 10,
   parameter int COLUMN_DISP_TIME       = 10,
   parameter int ANTIGHOSTING_TIME      = 10,
   parameter int N_COLUMNS              = 8,
   parameter int REQ_TIMEOUT            = 64,
   parameter int SLICE_CNT_W            = 8
) (
   input  logic                   clk_33,
   input  logic                   nrst,
   input  logic                   enable,
   input  logic                   slice_sync,
   input  logic                   drv_data_ready,
   input  logic                   clr_err,
   output logic                   drv_load_req,
   output logic [2:0]             col_idx,
   output logic                   column_ready,
   output logic                   busy,
   output logic [SLICE_CNT_W-1:0] slice_count,
   output logic                   overrun_err,
   output logic                   late_err
);

   localparam int MAX_A   = (SYNC_TO_FIRST_COL_TIME > COLUMN_DISP_TIME) ?
                            SYNC_TO_FIRST_COL_TIME : COLUMN_DISP_TIME;
   localparam int MAX_B   = (ANTIGHOSTING_TIME > REQ_TIMEOUT) ? ANTIGHOSTING_TIME : REQ_TIMEOUT;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(SYNC_TO_FIRST_COL_TIME - 1);
   localparam logic [CNT_W-1:0] REQ_LOAD   = CNT_W'(REQ_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DISP_LOAD  = CNT_W'(COLUMN_DISP_TIME - 1);
   localparam logic [CNT_W-1:0] GHOST_LOAD = CNT_W'(ANTIGHOSTING_TIME - 1);
   localparam logic [2:0]       LAST_COL   = 3'(N_COLUMNS - 1);

   typedef enum logic [2:0] {IDLE, WAIT_SYNC, SYNC_DELAY, REQ, HOLD, GHOST} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             restart;
   logic             cnt_zero;

   // A sync in any active state (including WAIT_SYNC) starts a fresh slice.
   assign restart  = slice_sync && (state != IDLE);
   assign cnt_zero = (cnt == '0);

   always_ff @(posedge clk_33 or negedge nrst) begin
      if (!nrst) begin
         state        <= IDLE;
         cnt          <= '0;
         drv_load_req <= 1'b0;
         col_idx      <= 3'd0;
         column_ready <= 1'b0;
         busy         <= 1'b0;
         slice_count  <= '0;
         overrun_err  <= 1'b0;
         late_err     <= 1'b0;
      end else begin
         column_ready <= 1'b0;
         if (clr_err) begin
            overrun_err <= 1'b0;
            late_err    <= 1'b0;
         end

         if (!enable) begin
            state        <= IDLE;
            drv_load_req <= 1'b0;
            col_idx      <= 3'd0;
            busy         <= 1'b0;
         end else if (restart) begin
            if (state != WAIT_SYNC)
               overrun_err <= 1'b1;
            // An ack taken in this same cycle still earns its column_ready pulse.
            if (state == REQ && drv_data_ready)
               column_ready <= 1'b1;
            state        <= SYNC_DELAY;
            cnt          <= SYNC_LOAD;
            col_idx      <= 3'd0;
            slice_count  <= slice_count + 1'b1;
            drv_load_req <= 1'b0;
            busy         <= 1'b1;
         end else begin
            case (state)
               IDLE: state <= WAIT_SYNC;
               SYNC_DELAY: begin
                  if (cnt_zero) begin
                     state        <= REQ;
                     cnt          <= REQ_LOAD;
                     drv_load_req <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               REQ: begin
                  if (drv_data_ready) begin
                     column_ready <= 1'b1;
                     state        <= HOLD;
                     cnt          <= DISP_LOAD;
                     drv_load_req <= 1'b0;
                  end else if (cnt_zero) begin
                     late_err     <= 1'b1;
                     state        <= GHOST;
                     cnt          <= GHOST_LOAD;
                     drv_load_req <= 1'b0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               HOLD: begin
                  if (cnt_zero) begin
                     state <= GHOST;
                     cnt   <= GHOST_LOAD;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               GHOST: begin
                  if (!cnt_zero) begin
                     cnt <= cnt - 1'b1;
                  end else if (col_idx == LAST_COL) begin
                     state <= WAIT_SYNC;
                     busy  <= 1'b0;
                  end else begin
                     state        <= REQ;
                     col_idx      <= col_idx + 1'b1;
                     cnt          <= REQ_LOAD;
                     drv_load_req <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_column_scheduler.sv
// Bench for column_scheduler: a driver model acks load requests and queues the expected
// column for each ack; a monitor pops and compares on every column_ready pulse.
module tb_column_scheduler;

   logic       clk_33 = 1'b0;
   logic       nrst;
   logic       enable;
   logic       slice_sync;
   logic       drv_data_ready;
   logic       clr_err;
   logic       drv_load_req;
   logic [2:0] col_idx;
   logic       column_ready;
   logic       busy;
   logic [7:0] slice_count;
   logic       overrun_err;
   logic       late_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cr_cnt  = 0;
   int req3_cycles = 0;
   int model_col = 0;
   int cur_col = 0;
   int skip_col = 99;
   int resp_en = 1;
   int sb_q[$];

   column_scheduler dut (
      .clk_33(clk_33), .nrst(nrst), .enable(enable), .slice_sync(slice_sync),
      .drv_data_ready(drv_data_ready), .clr_err(clr_err), .drv_load_req(drv_load_req),
      .col_idx(col_idx), .column_ready(column_ready), .busy(busy),
      .slice_count(slice_count), .overrun_err(overrun_err), .late_err(late_err)
   );

   always #15 clk_33 = ~clk_33;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0d", tag, got);
      end
   endtask

   // Driver model: acks two cycles into each request unless the column is being skipped.
   initial begin : responder
      logic req_prev;
      int   age;
      drv_data_ready = 1'b0;
      req_prev = 1'b0;
      age = 0;
      forever begin
         @(posedge clk_33); #1;
         drv_data_ready = 1'b0;
         if (drv_load_req && !req_prev) begin
            cur_col = model_col;
            model_col++;
            age = 0;
         end
         if (drv_load_req && resp_en != 0 && cur_col != skip_col) begin
            age++;
            if (age == 2) begin
               chk("req_col", 32'(col_idx), 32'(cur_col));
               drv_data_ready = 1'b1;
               sb_q.push_back(cur_col);
            end
         end
         req_prev = drv_load_req;
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk_33);
         if (nrst && drv_load_req && col_idx == 3'd3) req3_cycles++;
         if (nrst && column_ready) begin
            cr_cnt++;
            if (sb_q.size() == 0) chk("cr_unexpected", 32'(col_idx), 32'hFFFF);
            else chk("cr_col", 32'(col_idx), 32'(sb_q.pop_front()));
         end
      end
   end

   task automatic pulse_sync();
      @(posedge clk_33); #1;
      slice_sync = 1'b1;
      model_col = 0;
      @(posedge clk_33); #1;
      slice_sync = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 3000) begin
         @(posedge clk_33); #1;
         n++;
      end
      chk(tag, 32'(busy), 0);
   endtask

   task automatic measure_req(input string tag, input int exp);
      int n = 0;
      while (!drv_load_req && n < 200) begin
         @(posedge clk_33); #1;
         n++;
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   task automatic wait_cr_col(input logic [2:0] c);
      int n = 0;
      logic found = 1'b0;
      while (!found && n < 2000) begin
         @(negedge clk_33);
         if (column_ready && col_idx == c) found = 1'b1;
         n++;
      end
      chk("cr_seen", 32'(found), 1);
   endtask

   initial begin : main
      int cr0;
      int n;
      nrst = 1'b0; enable = 1'b0; slice_sync = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk_33);
      chk("rst_outs", {24'd0, drv_load_req, col_idx, column_ready, busy, overrun_err, late_err}, 0);
      chk("rst_cnt", 32'(slice_count), 0);
      @(posedge clk_33); #1; nrst = 1'b1;

      // 1: full slice with prompt acks
      enable = 1'b1;
      repeat (2) @(posedge clk_33);
      cr0 = cr_cnt;
      pulse_sync();
      measure_req("t1_first_req", 10);
      wait_idle("t1_idle");
      chk("t1_cr_count", 32'(cr_cnt - cr0), 8);
      chk("t1_slices", 32'(slice_count), 1);
      chk("t1_col_last", 32'(col_idx), 7);
      chk("t1_late", 32'(late_err), 0);

      // 2: column 3 never acked
      skip_col = 3; req3_cycles = 0; cr0 = cr_cnt;
      pulse_sync();
      wait_idle("t2_idle");
      chk("t2_req3_len", 32'(req3_cycles), 64);
      chk("t2_late", 32'(late_err), 1);
      chk("t2_cr_count", 32'(cr_cnt - cr0), 7);
      chk("t2_overrun", 32'(overrun_err), 0);
      skip_col = 99;
      @(posedge clk_33); #1; clr_err = 1'b1;
      @(posedge clk_33); #1; clr_err = 1'b0;
      chk("t2_clr", 32'(late_err), 0);

      // 3: sync during HOLD of column 5
      cr0 = cr_cnt;
      pulse_sync();
      wait_cr_col(3'd5);
      pulse_sync();
      chk("t3_overrun", 32'(overrun_err), 1);
      chk("t3_slices", 32'(slice_count), 4);
      measure_req("t3_restart_req", 10);
      chk("t3_col0", 32'(col_idx), 0);
      wait_idle("t3_idle");
      chk("t3_cr_count", 32'(cr_cnt - cr0), 14);

      // 4: enable dropped during REQ
      resp_en = 0;
      pulse_sync();
      measure_req("t4_req", 10);
      enable = 1'b0;
      @(posedge clk_33); #1;
      chk("t4_req_off", 32'(drv_load_req), 0);
      chk("t4_busy", 32'(busy), 0);
      pulse_sync();
      pulse_sync();
      repeat (15) @(posedge clk_33); #1;
      chk("t4_ignored_req", 32'(drv_load_req), 0);
      chk("t4_ignored_cnt", 32'(slice_count), 5);
      resp_en = 1;

      // 5: asynchronous reset mid-HOLD
      enable = 1'b1;
      repeat (2) @(posedge clk_33);
      pulse_sync();
      wait_cr_col(3'd1);
      #5 nrst = 1'b0;
      #1;
      chk("t5_async_outs", {24'd0, drv_load_req, col_idx, column_ready, busy, overrun_err, late_err}, 0);
      chk("t5_async_cnt", 32'(slice_count), 0);
      sb_q.delete();
      @(posedge clk_33); #1; nrst = 1'b1;
      repeat (15) @(posedge clk_33); #1;
      chk("t5_needs_sync", 32'(busy), 0);
      pulse_sync();
      measure_req("t5_req", 10);
      chk("t5_slices", 32'(slice_count), 1);
      wait_idle("t5_idle");

      // 6: slice counter wrap, then error clear
      resp_en = 0;
      for (int i = 0; i < 255; i++) begin
         pulse_sync();
         if (i == 253) chk("t6_cnt_255", 32'(slice_count), 255);
      end
      chk("t6_wrap", 32'(slice_count), 0);
      chk("t6_overrun", 32'(overrun_err), 1);
      n = 0;
      while (!late_err && n < 200) begin
         @(posedge clk_33); #1;
         n++;
      end
      chk("t6_late", 32'(late_err), 1);
      enable = 1'b0;
      @(posedge clk_33); #1; clr_err = 1'b1;
      @(posedge clk_33); #1; clr_err = 1'b0;
      chk("t6_clr", {30'd0, overrun_err, late_err}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
